// File: rtl/montgomery_mm.sv
// Radix-2 Montgomery modular multiplier: result = A*B*2^-WIDTH mod M.
// Both per-iteration additions are folded into one combinational step, so
// each bit of A costs one cycle; one product takes WIDTH+1 cycles.
// Optional macro FINAL_SUB_EN: SUB performs the conditional subtraction
// (result < M); when undefined, SUB only copies C (result < 2M, congruent).
module montgomery_mm #(
  parameter int unsigned WIDTH = 512,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH:0]   result,
  output logic             busy,
  output logic             done
);

  // Accumulator needs two guard bits: C < 2M and t + M < 4M.
  localparam int unsigned CW = WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOP = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    c_q, c_d;
  logic [WIDTH:0]   result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CW-1:0]    t_c;
  logic [CW-1:0]    u_c;
  logic [WIDTH:0]   result_sub_c;

  // One Montgomery iteration; A is shifted right so the current bit is a_q[0].
  always_comb begin
    t_c = c_q + (a_q[0] ? CW'(b_q) : '0);
    u_c = t_c + (t_c[0] ? CW'(m_q) : '0);
  end

`ifdef FINAL_SUB_EN
  logic [CW-1:0] d_c;

  // Conditional final subtraction: keep C - M unless it went negative.
  always_comb begin
    d_c          = c_q - CW'(m_q);
    result_sub_c = d_c[CW-1] ? c_q[WIDTH:0] : d_c[WIDTH:0];
  end
`else
  // Lazy reduction: pass C through, leaving result in [0, 2M).
  always_comb begin
    result_sub_c = c_q[WIDTH:0];
  end
`endif

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    c_d      = c_q;
    result_d = result_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = in_a;
          b_d     = in_b;
          m_d     = in_m;
          c_d     = '0;
          cnt_d   = '0;
          state_d = LOOP;
        end
      end
      LOOP: begin
        c_d   = u_c >> 1;
        a_d   = a_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = SUB;
        end
      end
      SUB: begin
        result_d = result_sub_c;
        state_d  = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == LOOP) || (state_d == SUB);
    done_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      c_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      c_q      <= c_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_montgomery_mm.sv
// Testbench for montgomery_mm: directed cases at WIDTH=8 plus randomised
// products at WIDTH=16 and WIDTH=64 against a modular-arithmetic model.
// Follows the DUT build: define FINAL_SUB_EN for both or neither.
module tb_montgomery_mm;

  logic clk = 1'b0;
  logic reset;

  logic       st8;
  logic [7:0] a8, b8, m8;
  logic [8:0] r8;
  logic       busy8, done8;

  logic        st16;
  logic [15:0] a16, b16, m16;
  logic [16:0] r16;
  logic        busy16, done16;

  logic        st64;
  logic [63:0] a64, b64, m64;
  logic [64:0] r64;
  logic        busy64, done64;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  montgomery_mm #(.WIDTH(8)) u_mm8 (
    .clk(clk), .reset(reset), .start(st8), .in_a(a8), .in_b(b8), .in_m(m8),
    .result(r8), .busy(busy8), .done(done8));

  montgomery_mm #(.WIDTH(16)) u_mm16 (
    .clk(clk), .reset(reset), .start(st16), .in_a(a16), .in_b(b16), .in_m(m16),
    .result(r16), .busy(busy16), .done(done16));

  montgomery_mm #(.WIDTH(64)) u_mm64 (
    .clk(clk), .reset(reset), .start(st64), .in_a(a64), .in_b(b64), .in_m(m64),
    .result(r64), .busy(busy64), .done(done64));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // A*B*2^-w mod M: reduce the product, then halve w times modulo odd M.
  function automatic logic [129:0] mont_ref(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] m, input int w);
    logic [129:0] p;
    p = (130'(a) * 130'(b)) % 130'(m);
    for (int i = 0; i < w; i++) begin
      p = p[0] ? ((p + 130'(m)) >> 1) : (p >> 1);
    end
    return p;
  endfunction

  function automatic int width_of(input int sel);
    return (sel == 0) ? 8 : (sel == 1) ? 16 : 64;
  endfunction

  function automatic logic [64:0] cur_res(input int sel);
    case (sel)
      0:       return 65'(r8);
      1:       return 65'(r16);
      default: return r64;
    endcase
  endfunction

  function automatic logic cur_done(input int sel);
    return (sel == 0) ? done8 : (sel == 1) ? done16 : done64;
  endfunction

  function automatic logic cur_busy(input int sel);
    return (sel == 0) ? busy8 : (sel == 1) ? busy16 : busy64;
  endfunction

  task automatic drive(input int sel, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] m, input logic st);
    case (sel)
      0:       begin a8 = a[7:0];   b8 = b[7:0];   m8 = m[7:0];   st8 = st;  end
      1:       begin a16 = a[15:0]; b16 = b[15:0]; m16 = m[15:0]; st16 = st; end
      default: begin a64 = a;       b64 = b;       m64 = m;       st64 = st; end
    endcase
  endtask

  // Pulse start for one cycle, then wait (bounded) for done.
  // lat = edges after the start edge until done is seen; bcnt = busy samples;
  // held = previous result unchanged until done.
  task automatic run_op(input int sel, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] m, output logic [64:0] res,
                        output int lat, output int bcnt, output bit held);
    logic [64:0] old;
    @(negedge clk);
    old = cur_res(sel);
    drive(sel, a, b, m, 1'b1);
    @(negedge clk);
    drive(sel, a, b, m, 1'b0);
    lat  = 0;
    bcnt = 0;
    held = 1'b1;
    while (!cur_done(sel) && lat < 400) begin
      if (cur_busy(sel)) bcnt++;
      if (cur_res(sel) !== old) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    res = cur_res(sel);
  endtask

  task automatic check_prod(input string tag, input logic [64:0] res, input logic [63:0] a,
                            input logic [63:0] b, input logic [63:0] m, input int w);
    logic [129:0] exp;
    exp = mont_ref(a, b, m, w);
`ifdef FINAL_SUB_EN
    check(tag, 128'(res), exp[127:0]);
`else
    check(tag, 128'(65'(res % 65'(m))), exp[127:0]);
    check({tag, "_lt2m"}, 128'(65'(res) < 65'(2 * 65'(m))), 128'(1));
`endif
  endtask

  task automatic full_op(input string tag, input int sel, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] m, input bit chk_held);
    logic [64:0] res;
    int lat, bcnt;
    bit held;
    int w;
    w = width_of(sel);
    run_op(sel, a, b, m, res, lat, bcnt, held);
    check({tag, "_lat"}, 128'(lat), 128'(w + 1));
    check({tag, "_busy"}, 128'(bcnt), 128'(w + 1));
    if (chk_held) check({tag, "_held"}, 128'(held), 128'(1));
    check_prod(tag, res, a, b, m, w);
  endtask

  logic [63:0] da [5] = '{64'd0,  64'd12, 64'd254, 64'd5, 64'd12};
  logic [63:0] db [5] = '{64'd12, 64'd0,  64'd254, 64'd7, 64'd12};
  logic [63:0] dm [5] = '{64'd13, 64'd13, 64'd255, 64'd13, 64'd13};

  initial begin
    logic [63:0] a, b, m;
    int j;

    reset = 1'b1;
    drive(0, '0, '0, '0, 1'b0);
    drive(1, '0, '0, '0, 1'b0);
    drive(2, '0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_result8", 128'(r8), 128'(0));
    check("rst_busy8", 128'(busy8), 128'(0));
    check("rst_done8", 128'(done8), 128'(0));
    check("rst_done64", 128'(done64), 128'(0));
    reset = 1'b0;

    // Directed WIDTH=8 cases; the last runs back-to-back from DONE with result=1 visible.
    for (int i = 0; i < 5; i++) begin
      full_op($sformatf("dir%0d", i), 0, da[i], db[i], dm[i], i == 4);
    end
    check("b2b_result_3", 128'(r8), 128'(3));

    // Start pulsed during LOOP cycle 3 with other operands must be ignored.
    @(negedge clk);
    drive(0, 64'd5, 64'd7, 64'd13, 1'b1);
    @(negedge clk);
    drive(0, 64'd5, 64'd7, 64'd13, 1'b0);
    j = 0;
    repeat (3) begin @(negedge clk); j++; end
    drive(0, 64'd9, 64'd11, 64'd15, 1'b1);
    @(negedge clk); j++;
    drive(0, 64'd9, 64'd11, 64'd15, 1'b0);
    while (!done8 && j < 400) begin @(negedge clk); j++; end
    check("ign_lat", 128'(j), 128'(9));
    check_prod("ign_res", 65'(r8), 64'd5, 64'd7, 64'd13, 8);

    // Reset in the middle of LOOP discards the run and clears the outputs.
    @(negedge clk);
    drive(0, 64'd12, 64'd12, 64'd13, 1'b1);
    @(negedge clk);
    drive(0, 64'd12, 64'd12, 64'd13, 1'b0);
    repeat (5) @(negedge clk);
    check("mid_busy_pre", 128'(busy8), 128'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", 128'(busy8), 128'(0));
    check("mid_rst_done", 128'(done8), 128'(0));
    check("mid_rst_result", 128'(r8), 128'(0));
    repeat (12) @(negedge clk);
    check("mid_rst_no_done", 128'(done8), 128'(0));
    full_op("after_rst", 0, 64'd5, 64'd7, 64'd13, 1'b1);

    // Randomised products at WIDTH=16 and WIDTH=64.
    for (int s = 1; s <= 2; s++) begin
      int w, n;
      w = width_of(s);
      n = (s == 1) ? 300 : 120;
      for (int i = 0; i < n; i++) begin
        m = {$urandom, $urandom};
        if (w < 64) m = m & ((64'd1 << w) - 64'd1);
        m[0] = 1'b1;
        if (m < 64'd3) m = 64'd3;
        a = {$urandom, $urandom} % m;
        b = {$urandom, $urandom} % m;
        if (i % 16 == 0) begin a = m - 64'd1; b = m - 64'd1; end
        full_op($sformatf("rnd_w%0d_%0d", w, i), s, a, b, m, 1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
